debounce_multi: RTL

Parametrised N-channel debouncer for buttons and switches. Each channel synchronises its raw input, qualifies it against a stability window, and produces a clean level plus single-cycle press and release strobes. An optional hold detector can also be compiled in. It sits between board pins (KEY/SW) and control FSMs, and supersedes the single-channel debouncer in new designs.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_multi_if.sv | 23 ++
 rtl/debounce_channel.sv | 104 ++++++++++
 rtl/debounce_multi.sv | 57 +++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and counter-width helper for the debounce_multi family.
package debounce_pkg;

  localparam int DEBOUNCE_DEFAULT_DELAY = 2500;
  localparam int DEBOUNCE_DEFAULT_HOLD  = 50_000_000;

  // Bits needed to hold every value 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button/status bundle between board pins and the debouncer; the debouncer takes the slave side.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
) ();

  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] released;
  logic [CHANNELS-1:0] held;
  logic                any_event;

  modport master (
    output button,
    input  level, pressed, released, held, any_event
  );

  modport slave (
    input  button,
    output level, pressed, released, held, any_event
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, clean level and edge strobes.
// The long-press detector is compiled in only when DEBOUNCE_HOLD_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DELAY_COUNTS = DEBOUNCE_DEFAULT_DELAY,
  parameter int HOLD_COUNTS  = DEBOUNCE_DEFAULT_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic pressed,
  output logic released,
  output logic held,
  output logic event_next
);

  localparam int              CW        = cnt_width(DELAY_COUNTS);
  localparam logic [CW-1:0]   DELAY_MAX = CW'(DELAY_COUNTS);

  if (DELAY_COUNTS < 1) begin : g_bad_delay
    $error("debounce_channel: DELAY_COUNTS must be >= 1");
  end
  if (HOLD_COUNTS < 1) begin : g_bad_hold
    $error("debounce_channel: HOLD_COUNTS must be >= 1");
  end

  logic [1:0]    sync_q;
  logic          sync;
  logic          prev;
  logic [CW-1:0] count;
  logic          update;
  logic          level_next;

  assign sync = sync_q[1];

  // NOTE: every variable written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    update     = 1'b0;
    level_next = level;
    if ((count == DELAY_MAX) && (prev != level)) begin
      update     = 1'b1;
      level_next = prev;
    end
  end

  assign event_next = update;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      prev     <= 1'b0;
      count    <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      prev   <= sync;
      // Any toggle restarts the window; a settled input parks the counter at the limit.
      if (sync != prev) begin
        count <= '0;
      end else if (count != DELAY_MAX) begin
        count <= count + CW'(1);
      end
      level    <= level_next;
      pressed  <= update && prev;
      released <= update && !prev;
    end
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam int            HW       = cnt_width(HOLD_COUNTS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_COUNTS);

  logic [HW-1:0] hold_count;
  logic [HW-1:0] hold_next;

  always_comb begin
    hold_next = hold_count;
    if (!level) begin
      hold_next = '0;
    end else if (hold_count != HOLD_MAX) begin
      hold_next = hold_count + HW'(1);
    end
  end

  // Gating with level_next drops held on the very edge that level falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_count <= '0;
      held       <= 1'b0;
    end else begin
      hold_count <= hold_next;
      held       <= level_next && (hold_next == HOLD_MAX);
    end
  end
`else
  assign held = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer: independent channels plus a registered any_event flag.
// Define DEBOUNCE_HOLD_EN to compile in the per-channel long-press (held) detector.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DELAY_COUNTS = DEBOUNCE_DEFAULT_DELAY,
  parameter int HOLD_COUNTS  = DEBOUNCE_DEFAULT_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  debounce_multi_if.slave  bus
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be >= 1");
  end

  logic [CHANNELS-1:0] level_v;
  logic [CHANNELS-1:0] pressed_v;
  logic [CHANNELS-1:0] released_v;
  logic [CHANNELS-1:0] held_v;
  logic [CHANNELS-1:0] event_next_v;
  logic                any_event_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DELAY_COUNTS (DELAY_COUNTS),
      .HOLD_COUNTS  (HOLD_COUNTS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .button     (bus.button[i]),
      .level      (level_v[i]),
      .pressed    (pressed_v[i]),
      .released   (released_v[i]),
      .held       (held_v[i]),
      .event_next (event_next_v[i])
    );
  end

  // Registered from the channels' next-strobe terms so it lines up with pressed/released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= |event_next_v;
    end
  end

  assign bus.level     = level_v;
  assign bus.pressed   = pressed_v;
  assign bus.released  = released_v;
  assign bus.held      = held_v;
  assign bus.any_event = any_event_q;

endmodule
